// File: rtl/rvc_fetch_align.sv
// Fetch alignment for RV32IC: pulls 16-bit and 32-bit instructions out of a word-wide
// asynchronous instruction memory at any halfword PC, including word-straddling ones.
module rvc_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_compressed
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] SPAN = 1'b1;

    // pc[0] is held at zero so the register maps straight onto instr_pc.
    logic [31:0] pc;
    logic [29:0] fa;
    logic [15:0] hbuf;
    logic [0:0]  st;

    logic [15:0] half;
    logic        half_c;
    logic        span_entry;
    logic        vld_raw;
    logic        comp_w;
    logic [31:0] instr_w;
    logic        accept;
    logic [31:0] pc_inc;

    function automatic logic is_compressed(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    always_comb begin
        half       = pc[1] ? imem_rdata[31:16] : imem_rdata[15:0];
        half_c     = is_compressed(half);
        span_entry = 1'b0;
        vld_raw    = 1'b1;
        comp_w     = half_c;
        instr_w    = {16'h0000, half};
        if (st == SPAN) begin
            instr_w = {imem_rdata[15:0], hbuf};
            comp_w  = 1'b0;
        end else if (!pc[1]) begin
            if (!half_c) begin
                instr_w = imem_rdata;
            end
        end else if (!half_c) begin
            // Upper half starts a 32-bit instruction: buffer it and fetch the next word.
            vld_raw    = 1'b0;
            span_entry = 1'b1;
        end
    end

    assign instr_valid      = vld_raw & ~redirect;
    assign instr            = instr_w;
    assign instr_compressed = comp_w;
    assign instr_pc         = pc;
    assign imem_addr        = {fa, 2'b00};
    assign accept           = instr_valid & instr_ready;
    assign pc_inc           = pc + (comp_w ? 32'd2 : 32'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc   <= RESET_PC & 32'hFFFF_FFFE;
            fa   <= RESET_PC[31:2];
            st   <= RUN;
            hbuf <= 16'h0000;
        end else if (redirect) begin
            pc <= redirect_pc & 32'hFFFF_FFFE;
            fa <= redirect_pc[31:2];
            st <= RUN;
        end else if (span_entry) begin
            hbuf <= imem_rdata[31:16];
            fa   <= fa + 30'd1;
            st   <= SPAN;
        end else if (accept) begin
            pc <= pc_inc;
            if (st == RUN) begin
                fa <= pc_inc[31:2];
            end else begin
                // fa already points at the word holding the new pc.
                st <= RUN;
            end
        end
    end

endmodule

// File: doc/rvc_fetch_align.md
# rvc_fetch_align

Instruction-fetch alignment stage between the word-wide instruction memory and the RV32IC decoder. It drives the word address into the asynchronous imem and takes back 32-bit words. It extracts 16-bit compressed and 32-bit base instructions at any halfword-aligned PC, including 32-bit instructions that straddle a word boundary. Each instruction is presented to decode with its PC under a valid/ready handshake, and a redirect input handles taken branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000, first instruction PC after reset; bit 0 ignored, halfword aligned.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  32  word-aligned fetch address, equal to {fa, 2'b00}.
- imem_rdata  in  32  word at imem_addr, combinational (same-cycle) read.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bit 0 forced to 0.
- instr_valid  out  1  instr, instr_pc and instr_compressed are valid this cycle.
- instr_ready  in  1  decode accepts; low means stall.
- instr  out  32  instruction; a compressed instruction is zero-extended ({16'h0, half}).
- instr_pc  out  32  PC of instr.
- instr_compressed  out  1  instr is 16-bit (half[1:0] != 2'b11).

## Operation
- State registers:
  - pc[31:1]: PC of the next instruction.
  - fa[29:0]: fetch word address.
  - hbuf[15:0]: buffered lower halfword of a spanning instruction.
  - st ∈ {RUN, SPAN}.
- RUN, invariant fa == pc[31:2]. Let W = imem_rdata.
  - pc[1]=0: half = W[15:0]. If compressed, output it; else instr = W. instr_valid=1.
  - pc[1]=1, half = W[31:16] compressed: output it, instr_valid=1.
  - pc[1]=1, half = W[31:16] not compressed: spanning instruction.
    - instr_valid=0.
    - hbuf <= W[31:16]; fa <= fa+1 (wraps mod 2^30); st <= SPAN.
    - This happens regardless of instr_ready.
  - Accept (valid & ready): pc <= pc+2 if compressed, else pc+4 (mod 2^32). fa <= new pc[31:2].
- SPAN, invariant fa == pc[31:2]+1.
  - instr = {W[15:0], hbuf}; instr_compressed=0; instr_valid=1.
  - Accept: pc <= pc+4; st <= RUN; fa unchanged (it already addresses the new pc's word).
- Stall (valid & !ready): all state holds and outputs stay stable, hbuf included.
- instr_pc = {pc, 1'b0} in both states.
- Redirect has priority over accept, span entry and stall.
  - instr_valid is forced to 0 in the redirect cycle; no handshake completes.
  - Next state: pc <= redirect_pc[31:1]; fa <= redirect_pc[31:2]; st <= RUN. hbuf is don't-care.
- Reset has priority over redirect.
  - pc <= RESET_PC[31:1]; fa <= RESET_PC[31:2]; st <= RUN; hbuf <= 0.
  - Reset mid-SPAN discards the buffered half.

## Timing
- Reset values, first cycle after reset deasserts: imem_addr = RESET_PC & ~3; instr_pc = RESET_PC & ~1; instr_valid follows the RUN rules on imem_rdata.
- Throughput is 1 instruction/cycle. The exception is a spanning 32-bit instruction: exactly one bubble cycle (RUN with valid=0), then valid in SPAN.
- Latency from PC to instr is 0 cycles: outputs are combinational from registers plus imem_rdata, with no registered instruction output.
- Redirect at cycle n: imem_addr and instr_pc reflect the target at n+1. The first target instruction can be valid at n+1, or at n+2 if the target is a spanning instruction.
- A redirect arriving during a SPAN bubble or a stall cancels everything; the stale instruction is never valid.
- Wrap: at pc=0xFFFF_FFFE, a spanning instruction sets fa to 0, so imem_addr=0x0000_0000. PC arithmetic wraps silently.

## Test plan
- Reset, RESET_PC=0, word0=0x00500093: instr_valid=1, instr=0x00500093, instr_pc=0, compressed=0. After accept, imem_addr=4 and instr_pc=4.
- Word0=0x4505_0001, ready=1:
  - Cycle A: instr=0x0000_0001, pc=0.
  - Cycle B: instr=0x0000_4505, pc=2.
  - imem_addr=0 in both cycles, then 4.
- Span, word0=0x0093_0001, word1=0x0000_0050:
  - c.nop at pc 0.
  - Bubble with valid=0, imem_addr moves to 4.
  - instr=0x00500093, pc=2, compressed=0.
  - After accept, instr_pc=6 and imem_addr=4.
- Same span with instr_ready=0 for 3 SPAN cycles: instr, instr_pc and imem_addr stay stable. Accept on the 4th cycle gives pc=6.
- Redirect to 0x102 during the span bubble:
  - Next cycle: imem_addr=0x100, instr_pc=0x102, st=RUN.
  - The old assembled instruction never asserts valid.
  - Redirect asserted together with ready=1 completes no handshake.
- Redirect to 0xFFFF_FFFE where the upper half is non-compressed: next-cycle imem_addr=0. Asserting reset during the resulting SPAN returns imem_addr and instr_pc to RESET_PC with st=RUN.
